// File: rtl/dbg_mux_sched.sv
// dbg_mux_sched: round-robin scheduler that multiplexes four 10-bit
// diagnostic sources into one valid/ready word stream with a minimum idle gap.
// Ports: cam_pclk, cam_resetn (async, active-low); src_value[39:0],
//   src_strobe[3:0], src_enable[3:0] in; out_word[12:0]={id,ovr,value},
//   out_valid out, out_ready in; drop_count[7:0] saturating lost-value count.
module dbg_mux_sched #(
  parameter logic [15:0] GAP_CYCLES = 16'd1000
) (
  input  logic        cam_pclk,
  input  logic        cam_resetn,
  input  logic [39:0] src_value,
  input  logic [3:0]  src_strobe,
  input  logic [3:0]  src_enable,
  output logic [12:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0][9:0]   hold_q, hold_d;
  logic [3:0]        pend_q, pend_d;
  logic [3:0]        ovr_q, ovr_d;
  logic [1:0]        last_q, last_d;
  logic [15:0]       gap_q, gap_d;
  logic [12:0]       word_q, word_d;
  logic              valid_q, valid_d;
  logic [7:0]        drop_q, drop_d;

  logic [3:0]        cand;
  logic              gnt_vld;
  logic [1:0]        gnt_id;
  logic [1:0]        idx;
  logic              do_grant;
  logic [2:0]        drops;
  logic [8:0]        drop_sum;

  assign out_word   = word_q;
  assign out_valid  = valid_q;
  assign drop_count = drop_q;

  // Rotating priority: search begins one past the last granted source.
  always_comb begin
    cand    = pend_q & src_enable;
    gnt_vld = 1'b0;
    gnt_id  = 2'd0;
    idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = last_q + 2'(i + 1);
      if (!gnt_vld && cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign do_grant = (state_q == S_IDLE) && gnt_vld;

  // Per-source capture. A strobe on the edge that grants the same source
  // refills the emptied slot rather than counting as an overwrite.
  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    drops  = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (!src_enable[k]) begin
        pend_d[k] = 1'b0;
        ovr_d[k]  = 1'b0;
      end else if (src_strobe[k]) begin
        hold_d[k] = src_value[10*k +: 10];
        if (do_grant && (gnt_id == 2'(k))) begin
          pend_d[k] = 1'b1;
          ovr_d[k]  = 1'b0;
        end else if (pend_q[k]) begin
          ovr_d[k] = 1'b1;
          drops    = drops + 3'd1;
        end else begin
          pend_d[k] = 1'b1;
          ovr_d[k]  = 1'b0;
        end
      end else if (do_grant && (gnt_id == 2'(k))) begin
        pend_d[k] = 1'b0;
        ovr_d[k]  = 1'b0;
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + {6'd0, drops};
    if (drop_sum > 9'd255) begin
      drop_d = 8'hFF;
    end else begin
      drop_d = drop_sum[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    word_d  = word_q;
    last_d  = last_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          word_d  = {gnt_id, ovr_q[gnt_id], hold_q[gnt_id]};
          valid_d = 1'b1;
          last_d  = gnt_id;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          gap_d   = 16'd0;
          if (GAP_CYCLES == 16'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // One cycle in IDLE follows, giving GAP_CYCLES+2 between words.
        if (gap_q == GAP_CYCLES - 16'd1) begin
          gap_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cam_pclk or negedge cam_resetn) begin
    if (!cam_resetn) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      pend_q  <= 4'd0;
      ovr_q   <= 4'd0;
      last_q  <= 2'd3;
      gap_q   <= 16'd0;
      word_q  <= 13'd0;
      valid_q <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

endmodule
